shared_ram_ctrl: RTL

//  Memory-side responder for the cache ram_* initiator interface. Serves N_PORTS caches

---
 rtl/shared_ram_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/shared_ram_ctrl.sv
// Round-robin multi-port front end for one fixed-latency word RAM.
// Optional SHARED_RAM_LOCK_EN: atomic lock of the RAM by one port.
module shared_ram_ctrl #(
  parameter int N_PORTS = 4,
  parameter int ADDR_W  = 10,
  parameter int RD_LAT  = 3,
  parameter int WR_LAT  = 2,
  parameter     INIT_FILE = ""
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [32*N_PORTS-1:0] ram_addr,
  input  logic [32*N_PORTS-1:0] ram_data_w,
  input  logic [N_PORTS-1:0]   ram_read,
  input  logic [N_PORTS-1:0]   ram_write,
  input  logic [N_PORTS-1:0]   ram_atomic,
  output logic [N_PORTS-1:0]   ram_wait,
  output logic [32*N_PORTS-1:0] ram_data_r,
  output logic [N_PORTS-1:0]   ram_grant
);

  localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CW = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state;
  logic [PW-1:0]       port;
  logic [PW-1:0]       rr;
  logic [ADDR_W-1:0]   addr;
  logic [31:0]         data;
  logic                op_wr;
  logic [CW-1:0]       cnt;
  logic [N_PORTS-1:0]  req;
  logic                found;
  logic [PW-1:0]       pick;
  logic [PW-1:0]       cand;
  logic                mem_we;
  logic                unused_in;

  logic [31:0] mem [2**ADDR_W];

`ifdef SHARED_RAM_LOCK_EN
  logic                lock_valid;
  logic [PW-1:0]       lock_port;
`endif

  assign req = ram_read | ram_write;
  assign unused_in = ^{ram_addr, ram_atomic};

  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      ram_wait[i] = req[i] & ~(state == DONE && port == PW'(i));
    end
  end

  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 1; k <= N_PORTS; k++) begin
      cand = PW'((int'(rr) + k) % N_PORTS);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
`ifdef SHARED_RAM_LOCK_EN
    // A locked RAM serves only its owner, even while the owner is idle.
    if (lock_valid) begin
      found = req[lock_port];
      pick  = lock_port;
    end
`endif
  end

  assign mem_we = (state == BUSY) && (cnt == '0) && op_wr;

  always_ff @(posedge clk) begin
    if (mem_we) mem[addr] <= data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      port       <= '0;
      rr         <= PW'(N_PORTS - 1);
      addr       <= '0;
      data       <= '0;
      op_wr      <= 1'b0;
      cnt        <= '0;
      ram_grant  <= '0;
      ram_data_r <= '0;
`ifdef SHARED_RAM_LOCK_EN
      lock_valid <= 1'b0;
      lock_port  <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            port  <= pick;
            addr  <= ram_addr[int'(pick)*32 +: ADDR_W];
            data  <= ram_data_w[int'(pick)*32 +: 32];
            op_wr <= ram_write[pick];
            cnt   <= ram_write[pick] ? CW'(WR_LAT - 1)
                                     : CW'(RD_LAT - 1);
            ram_grant       <= '0;
            ram_grant[pick] <= 1'b1;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            if (!op_wr) ram_data_r[int'(port)*32 +: 32] <= mem[addr];
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          rr        <= port;
          ram_grant <= '0;
`ifdef SHARED_RAM_LOCK_EN
          lock_valid <= ram_atomic[port];
          lock_port  <= port;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
